// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller.
// Holds the data word width, the request opcode encoding and the FSM state encoding.
// Imported by mem_access_ctrl; no logic lives here.
package mem_pkg;

    localparam int WORD_W = 12;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PTR_RD    = 3'd1,
        S_PTR_WAIT  = 3'd2,
        S_DATA_RD   = 3'd3,
        S_DATA_WAIT = 3'd4,
        S_WR        = 3'd5,
        S_RESP      = 3'd6
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory access controller: READ / WRITE / INC, optionally through a pointer word.
// Latency accept->RspValid: WRITE 2, READ 2+MEM_LAT, INC 3+MEM_LAT, reserved 1; indirect adds 1+MEM_LAT.
// Backpressure: ReqReady only in IDLE; the response is a one-cycle pulse that cannot be stalled.
// Ports: clk/rst; request ReqValid/ReqReady/ReqOp/ReqIndirect/ReqAddr/ReqWData;
//        response RspValid/RspData/RspZero/RspErr; memory MemRead/MemWrite/Address/WriteData/ReadData.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic              ReqIndirect,
    input  logic [WORD_W-1:0] ReqAddr,
    input  logic [WORD_W-1:0] ReqWData,
    output logic              RspValid,
    output logic [WORD_W-1:0] RspData,
    output logic              RspZero,
    output logic              RspErr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [WORD_W-1:0] Address,
    output logic [WORD_W-1:0] WriteData,
    input  logic [WORD_W-1:0] ReadData
);

    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;      // caller's store data, kept for WRITE
    logic [WORD_W-1:0] addr_q, addr_d;        // drives Address; only moves on entry to a strobe state
    logic [WORD_W-1:0] wout_q, wout_d;        // drives WriteData; only moves on entry to WR
    logic [1:0]        cnt_q, cnt_d;          // wait cycles remaining minus one
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        wout_d     = wout_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    op_d    = op_e'(ReqOp);
                    wdata_d = ReqWData;
                    // Reserved ops never touch memory, even when flagged indirect.
                    if (op_e'(ReqOp) == OP_RSVD) begin
                        state_d    = S_RESP;
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b1;
                        rsp_err_d  = 1'b1;
                    end else begin
                        addr_d = ReqAddr;
                        if (ReqIndirect) begin
                            state_d = S_PTR_RD;
                        end else if (op_e'(ReqOp) == OP_WRITE) begin
                            state_d = S_WR;
                            wout_d  = ReqWData;
                        end else begin
                            state_d = S_DATA_RD;
                        end
                    end
                end
            end
            S_PTR_RD: begin
                state_d = S_PTR_WAIT;
                cnt_d   = WAIT_LAST;
            end
            S_PTR_WAIT: begin
                if (cnt_q == 2'd0) begin
                    addr_d = ReadData;
                    if (op_q == OP_WRITE) begin
                        state_d = S_WR;
                        wout_d  = wdata_q;
                    end else begin
                        state_d = S_DATA_RD;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DATA_RD: begin
                state_d = S_DATA_WAIT;
                cnt_d   = WAIT_LAST;
            end
            S_DATA_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (op_q == OP_INC) begin
                        state_d = S_WR;
                        wout_d  = ReadData + 12'd1;   // 12-bit add wraps FFF to 000
                    end else begin
                        state_d    = S_RESP;
                        rsp_data_d = ReadData;
                        rsp_zero_d = (ReadData == '0);
                        rsp_err_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WR: begin
                // Both WRITE and INC report the value just stored.
                state_d    = S_RESP;
                rsp_data_d = wout_q;
                rsp_zero_d = (wout_q == '0);
                rsp_err_d  = 1'b0;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_READ;
            wdata_q    <= '0;
            addr_q     <= '0;
            wout_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            wout_q     <= wout_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Strobes decode straight from state so reset drops them immediately.
    assign ReqReady  = (state_q == S_IDLE);
    assign MemRead   = (state_q == S_PTR_RD) || (state_q == S_DATA_RD);
    assign MemWrite  = (state_q == S_WR);
    assign RspValid  = (state_q == S_RESP);
    assign Address   = addr_q;
    assign WriteData = wout_q;
    assign RspData   = rsp_data_q;
    assign RspZero   = rsp_zero_q;
    assign RspErr    = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with MEM_LAT=1 and a behavioural memory.
// Each request is traced cycle by cycle (cycle 0 = accept cycle) and checked against hand-derived values.
// A negedge monitor checks strobe exclusivity and idle gaps throughout the run.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid, ReqReady, ReqIndirect;
    logic [1:0]  ReqOp;
    logic [11:0] ReqAddr, ReqWData;
    logic        RspValid, RspZero, RspErr, MemRead, MemWrite;
    logic [11:0] RspData, Address, WriteData, ReadData;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqIndirect(ReqIndirect), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspData(RspData), .RspZero(RspZero), .RspErr(RspErr),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    // Memory: read data is captured at the strobe edge and presented during the following cycle.
    logic [11:0] mem [0:4095];
    logic [11:0] rd_q = '0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0, poke_dat = '0;
    always @(posedge clk) begin
        if (poke_en)  mem[poke_addr] <= poke_dat;
        if (MemRead)  rd_q <= mem[Address];
        if (MemWrite) mem[Address] <= WriteData;
    end
    assign ReadData = rd_q;

    // Strobe monitor: never both strobes, never two strobe cycles back to back.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (MemRead || MemWrite) begin
            n_cmp++;
            if (MemRead && MemWrite) begin
                n_fail++;
                $display("FAIL strobe_excl: MemRead=%0b MemWrite=%0b required not both", MemRead, MemWrite);
            end
            n_cmp++;
            if (prev_strobe) begin
                n_fail++;
                $display("FAIL strobe_gap: strobe at %0t follows strobe, required idle cycle", $time);
            end
        end
        prev_strobe = MemRead || MemWrite;
    end

    logic        tr_mr[0:15], tr_mw[0:15], tr_rv[0:15], tr_zero[0:15], tr_err[0:15], tr_rdy[0:15];
    logic [11:0] tr_addr[0:15], tr_wd[0:15], tr_rdat[0:15];

    task automatic sample(input int c);
        tr_mr[c] = MemRead;   tr_mw[c] = MemWrite; tr_rv[c] = RspValid;
        tr_zero[c] = RspZero; tr_err[c] = RspErr;  tr_rdy[c] = ReqReady;
        tr_addr[c] = Address; tr_wd[c] = WriteData; tr_rdat[c] = RspData;
    endtask

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_dat = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Presents one request for the accept cycle, then scrambles the inputs so only registered values matter.
    task automatic run_req(input logic [1:0] op, input logic ind, input logic [11:0] addr,
                           input logic [11:0] wd, input int n);
        @(negedge clk);
        ReqValid = 1'b1; ReqOp = op; ReqIndirect = ind; ReqAddr = addr; ReqWData = wd;
        sample(0);
        @(posedge clk); #1;
        ReqValid = 1'b0; ReqOp = ~op; ReqIndirect = ~ind; ReqAddr = ~addr; ReqWData = ~wd;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            sample(c);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ReqValid = 1'b1; ReqOp = 2'b01; ReqIndirect = 1'b0; ReqAddr = 12'd3; ReqWData = 12'd9;
        repeat (2) @(negedge clk);
        n_cmp++; if ({MemRead, MemWrite, RspValid, RspZero, RspErr} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 00000", {MemRead, MemWrite, RspValid, RspZero, RspErr}); end
        n_cmp++; if (Address !== 12'd0 || WriteData !== 12'd0) begin
            n_fail++; $display("FAIL reset_addr: Address=%0d WriteData=%0d want 0 0", Address, WriteData); end
        n_cmp++; if (RspData !== 12'd0) begin
            n_fail++; $display("FAIL reset_rspdata: got %0d want 0", RspData); end
        n_cmp++; if (ReqReady !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", ReqReady); end
        ReqValid = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (MemWrite !== 1'b0 || MemRead !== 1'b0 || RspValid !== 1'b0) begin
                n_fail++; $display("FAIL reset_noaccept: cycle %0d MemRead=%b MemWrite=%b RspValid=%b want 000",
                                   c, MemRead, MemWrite, RspValid); end
        end
    endtask

    task automatic test_direct_read;
        run_req(2'b00, 1'b0, 12'd1000, 12'd0, 4);
        n_cmp++; if (tr_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL rd_ready0: got %b want 1", tr_rdy[0]); end
        n_cmp++; if (tr_mr[1] !== 1'b1 || tr_addr[1] !== 12'd1000) begin
            n_fail++; $display("FAIL rd_strobe: MemRead=%b Address=%0d want 1 1000", tr_mr[1], tr_addr[1]); end
        n_cmp++; if (tr_rv[2] !== 1'b0 || tr_rv[3] !== 1'b1 || tr_rv[4] !== 1'b0) begin
            n_fail++; $display("FAIL rd_rspvalid: c2..4=%b%b%b want 010", tr_rv[2], tr_rv[3], tr_rv[4]); end
        n_cmp++; if (tr_rdat[3] !== 12'd1 || tr_zero[3] !== 1'b0 || tr_err[3] !== 1'b0) begin
            n_fail++; $display("FAIL rd_rsp: data=%0d zero=%b err=%b want 1 0 0", tr_rdat[3], tr_zero[3], tr_err[3]); end
        n_cmp++; if (tr_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL rd_busy: got %b want 0", tr_rdy[1]); end
    endtask

    task automatic test_indirect_read;
        run_req(2'b00, 1'b1, 12'd40, 12'd0, 6);
        n_cmp++; if (tr_mr[1] !== 1'b1 || tr_addr[1] !== 12'd40) begin
            n_fail++; $display("FAIL ird_ptr: MemRead=%b Address=%0d want 1 40", tr_mr[1], tr_addr[1]); end
        n_cmp++; if (tr_mr[3] !== 1'b1 || tr_addr[3] !== 12'd1000) begin
            n_fail++; $display("FAIL ird_data: MemRead=%b Address=%0d want 1 1000", tr_mr[3], tr_addr[3]); end
        n_cmp++; if (tr_rv[4] !== 1'b0 || tr_rv[5] !== 1'b1) begin
            n_fail++; $display("FAIL ird_rspvalid: c4=%b c5=%b want 0 1", tr_rv[4], tr_rv[5]); end
        n_cmp++; if (tr_rdat[5] !== 12'd1) begin
            n_fail++; $display("FAIL ird_data_val: got %0d want 1", tr_rdat[5]); end
        n_cmp++; if (tr_mw[1] || tr_mw[2] || tr_mw[3] || tr_mw[4] || tr_mw[5]) begin
            n_fail++; $display("FAIL ird_nowrite: MemWrite seen, want none"); end
    endtask

    task automatic test_direct_inc;
        run_req(2'b10, 1'b0, 12'd43, 12'd0, 5);
        n_cmp++; if (tr_mr[1] !== 1'b1 || tr_addr[1] !== 12'd43) begin
            n_fail++; $display("FAIL inc_rd: MemRead=%b Address=%0d want 1 43", tr_mr[1], tr_addr[1]); end
        n_cmp++; if (tr_mw[3] !== 1'b1 || tr_addr[3] !== 12'd43 || tr_wd[3] !== 12'd0) begin
            n_fail++; $display("FAIL inc_wr: MemWrite=%b Address=%0d WriteData=%0d want 1 43 0", tr_mw[3], tr_addr[3], tr_wd[3]); end
        n_cmp++; if (tr_rv[4] !== 1'b1 || tr_zero[4] !== 1'b1 || tr_rdat[4] !== 12'd0) begin
            n_fail++; $display("FAIL inc_rsp: valid=%b zero=%b data=%0d want 1 1 0", tr_rv[4], tr_zero[4], tr_rdat[4]); end
        n_cmp++; if (tr_rv[3] !== 1'b0) begin n_fail++; $display("FAIL inc_early: got %b want 0", tr_rv[3]); end
        n_cmp++; if (mem[43] !== 12'd0) begin n_fail++; $display("FAIL inc_mem: mem[43]=%0d want 0", mem[43]); end
    endtask

    task automatic test_indirect_write;
        run_req(2'b01, 1'b1, 12'd42, 12'd11, 5);
        n_cmp++; if (tr_mr[1] !== 1'b1 || tr_addr[1] !== 12'd42) begin
            n_fail++; $display("FAIL iwr_ptr: MemRead=%b Address=%0d want 1 42", tr_mr[1], tr_addr[1]); end
        n_cmp++; if (tr_mw[3] !== 1'b1 || tr_addr[3] !== 12'd3000 || tr_wd[3] !== 12'd11) begin
            n_fail++; $display("FAIL iwr_wr: MemWrite=%b Address=%0d WriteData=%0d want 1 3000 11", tr_mw[3], tr_addr[3], tr_wd[3]); end
        n_cmp++; if (tr_rv[4] !== 1'b1 || tr_rdat[4] !== 12'd11 || tr_err[4] !== 1'b0) begin
            n_fail++; $display("FAIL iwr_rsp: valid=%b data=%0d err=%b want 1 11 0", tr_rv[4], tr_rdat[4], tr_err[4]); end
        n_cmp++; if (tr_addr[4] !== 12'd3000 || tr_wd[5] !== 12'd11) begin
            n_fail++; $display("FAIL iwr_hold: Address=%0d WriteData=%0d want 3000 11", tr_addr[4], tr_wd[5]); end
        n_cmp++; if (mem[3000] !== 12'd11) begin n_fail++; $display("FAIL iwr_mem: mem[3000]=%0d want 11", mem[3000]); end
    endtask

    task automatic test_reset_mid_op;
        int seen;
        @(negedge clk);
        ReqValid = 1'b1; ReqOp = 2'b00; ReqIndirect = 1'b0; ReqAddr = 12'd1000; ReqWData = 12'd0;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;          // now in the data wait cycle
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({MemRead, MemWrite, RspValid} !== 3'b000 || ReqReady !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_now: strobes/rv=%b ready=%b want 000 1", {MemRead, MemWrite, RspValid}, ReqReady); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (RspValid || MemRead || MemWrite) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_abort: %0d active cycles want 0", seen); end
        run_req(2'b00, 1'b0, 12'd1000, 12'd0, 4);
        n_cmp++; if (tr_mr[1] !== 1'b1 || tr_addr[1] !== 12'd1000) begin
            n_fail++; $display("FAIL rstmid_rd: MemRead=%b Address=%0d want 1 1000", tr_mr[1], tr_addr[1]); end
        n_cmp++; if (tr_rv[2] !== 1'b0 || tr_rv[3] !== 1'b1 || tr_rdat[3] !== 12'd1) begin
            n_fail++; $display("FAIL rstmid_rsp: c2=%b c3=%b data=%0d want 0 1 1", tr_rv[2], tr_rv[3], tr_rdat[3]); end
    endtask

    task automatic test_back_to_back;
        // Per-cycle drive: {valid, op, addr, wdata}
        logic        v_t  [0:6] = '{1, 1, 1, 1, 1, 1, 0};
        logic [1:0]  op_t [0:6] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [11:0] a_t  [0:6] = '{12'd5, 12'd7, 12'd7, 12'd9, 12'd9, 12'd9, 12'd0};
        logic [11:0] d_t  [0:6] = '{12'd0, 12'd55, 12'd55, 12'd0, 12'd0, 12'd0, 12'd0};
        logic        rdy_exp [0:6] = '{1, 0, 1, 0, 0, 1, 0};
        logic        rv_exp  [0:6] = '{0, 1, 0, 0, 1, 0, 1};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ReqValid = v_t[c]; ReqOp = op_t[c]; ReqIndirect = 1'b0; ReqAddr = a_t[c]; ReqWData = d_t[c];
            sample(c);
        end
        ReqValid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            n_cmp++; if (tr_rdy[c] !== rdy_exp[c] || tr_rv[c] !== rv_exp[c]) begin
                n_fail++; $display("FAIL b2b_hs c%0d: ready=%b rv=%b want %b %b", c, tr_rdy[c], tr_rv[c], rdy_exp[c], rv_exp[c]); end
            n_cmp++; if (tr_mr[c] !== 1'b0 || tr_mw[c] !== (c == 3)) begin
                n_fail++; $display("FAIL b2b_strobe c%0d: MemRead=%b MemWrite=%b want 0 %b", c, tr_mr[c], tr_mw[c], c == 3); end
        end
        n_cmp++; if (tr_err[1] !== 1'b1 || tr_rdat[1] !== 12'd0 || tr_zero[1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_rsvd1: err=%b data=%0d zero=%b want 1 0 1", tr_err[1], tr_rdat[1], tr_zero[1]); end
        n_cmp++; if (tr_err[2] !== 1'b1 || tr_rdat[3] !== 12'd0) begin
            n_fail++; $display("FAIL b2b_hold: err=%b data=%0d want 1 0", tr_err[2], tr_rdat[3]); end
        n_cmp++; if (tr_addr[3] !== 12'd7 || tr_wd[3] !== 12'd55) begin
            n_fail++; $display("FAIL b2b_wr: Address=%0d WriteData=%0d want 7 55", tr_addr[3], tr_wd[3]); end
        n_cmp++; if (tr_rdat[4] !== 12'd55 || tr_err[4] !== 1'b0 || tr_zero[4] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_wrsp: data=%0d err=%b zero=%b want 55 0 0", tr_rdat[4], tr_err[4], tr_zero[4]); end
        n_cmp++; if (tr_err[6] !== 1'b1 || tr_rdat[6] !== 12'd0 || tr_addr[6] !== 12'd7) begin
            n_fail++; $display("FAIL b2b_rsvd2: err=%b data=%0d Address=%0d want 1 0 7", tr_err[6], tr_rdat[6], tr_addr[6]); end
        n_cmp++; if (mem[7] !== 12'd55) begin n_fail++; $display("FAIL b2b_mem: mem[7]=%0d want 55", mem[7]); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        poke(12'd1000, 12'd1);
        poke(12'd40,   12'd1000);
        poke(12'd43,   12'hFFF);
        poke(12'd42,   12'd3000);
        test_direct_read;
        test_indirect_read;
        test_direct_inc;
        test_indirect_write;
        test_reset_mid_op;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
